// File: rtl/buff_frame_reader.sv
// rtl/buff_frame_reader.sv - frame buffer read sequencer
// Streams FRAME_LEN words from framenum*HOP (mod 2^ADDR_W) through a 2-entry output FIFO.
module buff_frame_reader #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 400,
  parameter int HOP       = 160
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        framenum,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_framenum,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [8:0]        out_index,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [8:0]        issue_cnt_q, issue_cnt_d;
  logic [8:0]        wr_idx_q, wr_idx_d;
  logic [7:0]        frame_q, frame_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [8:0]        fifo_idx_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;
  logic [2:0]        occ;
  logic              push, pop;

  assign out_valid    = (cnt_q != 2'd0);
  assign pop          = out_valid & out_ready;
  assign push         = inflight_q;
  assign out_data     = fifo_data_q[rd_ptr_q];
  assign out_index    = fifo_idx_q[rd_ptr_q];
  assign out_last     = out_valid && (out_index == 9'(FRAME_LEN - 1));
  assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign mem_address  = base_q + ADDR_W'(issue_cnt_q);
  assign mem_framenum = frame_q;

  // Occupancy counts the word leaving this cycle so a full pipeline sustains 1 word/clk.
  assign occ = {1'b0, cnt_q} + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    wr_idx_d    = push ? wr_idx_q + 9'd1 : wr_idx_q;
    frame_d     = frame_q;
    mem_rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d     = framenum;
          base_d      = ADDR_W'({9'd0, framenum} * 17'(HOP));
          issue_cnt_d = 9'd0;
          wr_idx_d    = 9'd0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (occ < 3'd2) begin
          mem_rd_en   = 1'b1;
          issue_cnt_d = issue_cnt_q + 9'd1;
          if (issue_cnt_q == 9'(FRAME_LEN - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      wr_idx_q    <= '0;
      frame_q     <= '0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      wr_idx_q    <= wr_idx_d;
      frame_q     <= frame_d;
      inflight_q  <= mem_rd_en;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_data_out;
        fifo_idx_q[wr_ptr_q]  <= wr_idx_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_buff_frame_reader.sv
// tb/tb_buff_frame_reader.sv - scoreboard bench for buff_frame_reader
module tb_buff_frame_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  framenum = 8'd0;
  logic        busy, done, mem_rd_en, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [12:0] mem_address;
  logic [7:0]  mem_framenum;
  logic [31:0] mem_data_out = 32'd0;
  logic [31:0] out_data;
  logic [8:0]  out_index;

  buff_frame_reader dut (
    .clk(clk), .reset(reset), .start(start), .framenum(framenum),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_address(mem_address),
    .mem_framenum(mem_framenum), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int last_acc = -10;
  int bubbles = 0;
  bit bubble_watch = 1'b0;
  bit hold_chk = 1'b0;
  logic [41:0] held;
  int ready_mode = 0;
  logic [63:0] exp_q[$];
  logic [12:0] addr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [12:0] a);
    return {a ^ 13'h1A5A, 6'h2C, a};
  endfunction

  // Buffer model: data valid exactly one cycle after the read strobe, junk otherwise.
  always @(posedge clk)
    mem_data_out <= mem_rd_en ? memf(mem_address) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", 64'(mem_address), 64'(addr_q.pop_front()));
      end
      if (hold_chk) check("hold", {out_valid, out_last, out_index, out_data}, {1'b1, held});
      hold_chk = out_valid && !out_ready;
      held = {out_last, out_index, out_data};
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (out_last) last_acc = cyc;
        if (exp_q.size() == 0) check("word_extra", 1, 0);
        else check("word", 64'({out_last, out_index, out_data}), exp_q.pop_front());
      end
      if (bubble_watch && busy && !out_valid) bubbles++;
      if (done) begin
        done_cnt++;
        check("done_lat", 64'(cyc), 64'(last_acc + 1));
        check("done_busy", 64'(busy), 0);
      end
    end
  end

  task automatic do_start(input logic [7:0] fn);
    @(posedge clk); #1;
    start = 1'b1;
    framenum = fn;
    for (int i = 0; i < 400; i++) begin
      logic [12:0] a;
      a = 13'(int'(fn) * 160 + i);
      addr_q.push_back(a);
      exp_q.push_back(64'({(i == 399), 9'(i), memf(a)}));
    end
    @(posedge clk); #1;
    start = 1'b0;
    framenum = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 1);
    check({tag, "_exp_left"}, 64'(exp_q.size()), 0);
    check({tag, "_addr_left"}, 64'(addr_q.size()), 0);
    check({tag, "_idle"}, {busy, out_valid}, 0);
  endtask

  task automatic wait_acc(input int n_acc);
    int n = 0;
    int a0 = acc_cnt;
    while (acc_cnt - a0 < n_acc && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("acc_wait", 64'(acc_cnt - a0 >= n_acc), 1);
  endtask

  initial begin
    int lat;
    int r0;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, mem_rd_en, out_valid, out_last}, 0);
    check("rst_addr", 64'(mem_address), 0);
    check("rst_fn", 64'(mem_framenum), 0);
    check("rst_data", 64'(out_data), 0);
    check("rst_idx", 64'(out_index), 0);
    reset = 1'b0;

    // 1: frame 0, ready always high
    r0 = rd_cnt;
    do_start(8'd0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_lat", 64'(lat), 2);
    wait_done("t1");
    check("t1_reads", 64'(rd_cnt - r0), 400);

    // 2: address wrap from 8191 to 0
    do_start(8'd255);
    wait_done("t2");

    // 3: random backpressure
    ready_mode = 1;
    do_start(8'd3);
    wait_done("t3");

    // 4: long stall then release without bubbles
    ready_mode = 2;
    repeat (2) @(posedge clk);
    r0 = rd_cnt;
    do_start(8'd7);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (20) @(posedge clk);
    check("stall_reads", 64'(rd_cnt - r0 <= 2), 1);
    #1;
    ready_mode = 0;
    @(posedge clk); #3;
    bubbles = 0;
    bubble_watch = 1'b1;
    wait_done("t4");
    bubble_watch = 1'b0;
    check("t4_bubbles", 64'(bubbles), 0);

    // 5: reset mid-frame, then frame 1
    do_start(8'd2);
    wait_acc(150);
    #1;
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    check("t5_rst_state", {busy, out_valid, done, mem_rd_en}, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", 64'(done_cnt - d0), 0);
    do_start(8'd1);
    check("t5_fn", 64'(mem_framenum), 1);
    wait_done("t5");

    // 6: start while busy is ignored
    r0 = rd_cnt;
    do_start(8'd2);
    wait_acc(50);
    #1;
    start = 1'b1;
    framenum = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_fn_keep", 64'(mem_framenum), 2);
    check("t6_busy", 64'(busy), 1);
    wait_done("t6");
    check("t6_reads", 64'(rd_cnt - r0), 400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
